// File: rtl/keypad_password_entry.sv
// rtl/keypad_password_entry.sv - collects keypad digits into an 11-bit code and submits it on ENTER
module keypad_password_entry #(
    parameter int MAX_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [10:0] entered_password,
    output logic        password_ready,
    output logic        change_mode,
    output logic        entry_active,
    output logic [2:0]  digit_count,
    output logic        entry_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [3:0] KEY_CHANGE = 4'hC;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        SUBMIT = 2'd2
    } state_t;

    state_t        state;
    logic [10:0]   acc;
    logic          overflow;
    logic [TW-1:0] timer;

    logic          is_digit;
    logic [14:0]   next_val;
    logic          digit_fits;

    // Candidate accumulator value for a new digit, wide enough that the 2047 check never wraps
    always_comb begin
        is_digit   = (key_code <= 4'd9);
        next_val   = 15'(acc) * 15'd10 + 15'(key_code);
        digit_fits = (digit_count != 3'(MAX_DIGITS)) && (next_val <= 15'd2047);
    end

    // Entry state machine; change_mode and digit_count are the armed flag and counter themselves
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            acc              <= '0;
            digit_count      <= '0;
            overflow         <= 1'b0;
            change_mode      <= 1'b0;
            timer            <= '0;
            entered_password <= '0;
            password_ready   <= 1'b0;
            entry_error      <= 1'b0;
            entry_active     <= 1'b0;
        end else begin
            password_ready <= 1'b0;
            entry_error    <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (key_valid) begin
                        if (is_digit) begin
                            acc          <= 11'(key_code);
                            digit_count  <= 3'd1;
                            overflow     <= 1'b0;
                            state        <= ENTRY;
                            entry_active <= 1'b1;
                        end else if (key_code == KEY_CHANGE) begin
                            change_mode <= 1'b1;
                        end else if (key_code == KEY_CLEAR) begin
                            change_mode <= 1'b0;
                        end
                    end
                end
                ENTRY: begin
                    if (key_valid && key_code <= KEY_CHANGE) begin
                        timer <= '0;
                        if (is_digit) begin
                            if (digit_fits) begin
                                acc         <= next_val[10:0];
                                digit_count <= digit_count + 3'd1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else if (key_code == KEY_CHANGE) begin
                            change_mode <= 1'b1;
                        end else if (key_code == KEY_ENTER && !overflow) begin
                            entered_password <= acc;
                            password_ready   <= 1'b1;
                            state            <= SUBMIT;
                            entry_active     <= 1'b0;
                        end else begin
                            // CLEAR, or ENTER after an overflowed digit
                            entry_error  <= (key_code == KEY_ENTER);
                            acc          <= '0;
                            digit_count  <= '0;
                            overflow     <= 1'b0;
                            change_mode  <= 1'b0;
                            state        <= IDLE;
                            entry_active <= 1'b0;
                        end
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        entry_error  <= 1'b1;
                        timer        <= '0;
                        acc          <= '0;
                        digit_count  <= '0;
                        overflow     <= 1'b0;
                        change_mode  <= 1'b0;
                        state        <= IDLE;
                        entry_active <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SUBMIT: begin
                    // Keys arriving during the submit cycle are dropped
                    timer       <= '0;
                    acc         <= '0;
                    digit_count <= '0;
                    overflow    <= 1'b0;
                    change_mode <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    entry_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_password_entry.sv
// tb/tb_keypad_password_entry.sv - directed self-checking bench for keypad_password_entry
module tb_keypad_password_entry;

    localparam logic [3:0] K_CLEAR  = 4'hA;
    localparam logic [3:0] K_ENTER  = 4'hB;
    localparam logic [3:0] K_CHANGE = 4'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [10:0] entered_password;
    logic        password_ready;
    logic        change_mode;
    logic        entry_active;
    logic [2:0]  digit_count;
    logic        entry_error;

    int n_cmp = 0;
    int n_bad = 0;

    keypad_password_entry #(
        .MAX_DIGITS     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .key_valid        (key_valid),
        .key_code         (key_code),
        .entered_password (entered_password),
        .password_ready   (password_ready),
        .change_mode      (change_mode),
        .entry_active     (entry_active),
        .digit_count      (digit_count),
        .entry_error      (entry_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one key for one edge; returns at the falling edge after that edge
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        idle(3);
        reset = 1'b0;

        // reset state
        check("rst_pw",     32'(entered_password), 32'h0);
        check("rst_ready",  32'(password_ready),   32'h0);
        check("rst_change", 32'(change_mode),      32'h0);
        check("rst_active", 32'(entry_active),     32'h0);
        check("rst_count",  32'(digit_count),      32'h0);
        check("rst_error",  32'(entry_error),      32'h0);

        // 1: 1,2,3,4,ENTER submits 1234
        press(4'd1);
        check("t1_active", 32'(entry_active), 32'h1);
        press(4'd2);
        press(4'd3);
        press(4'd4);
        check("t1_count4", 32'(digit_count), 32'd4);
        press(K_ENTER);
        check("t1_ready",  32'(password_ready),   32'h1);
        check("t1_pw",     32'(entered_password), 32'h4D2);
        check("t1_err",    32'(entry_error),      32'h0);
        idle(1);
        check("t1_ready_off", 32'(password_ready), 32'h0);
        check("t1_count0",    32'(digit_count),    32'd0);
        check("t1_idle",      32'(entry_active),   32'h0);
        idle(2);

        // 2: 2048 overflows
        press(4'd2);
        press(4'd0);
        press(4'd4);
        press(4'd8);
        check("t2_count3", 32'(digit_count), 32'd3);
        press(K_ENTER);
        check("t2_err",   32'(entry_error),      32'h1);
        check("t2_ready", 32'(password_ready),   32'h0);
        check("t2_pw",    32'(entered_password), 32'h4D2);
        idle(1);
        check("t2_err_off",   32'(entry_error),    32'h0);
        check("t2_ready_off", 32'(password_ready), 32'h0);
        check("t2_active",    32'(entry_active),   32'h0);
        idle(2);

        // 3: fifth digit overflows the digit limit
        for (int i = 0; i < 5; i++) press(4'd1);
        check("t3_count4", 32'(digit_count), 32'd4);
        press(K_ENTER);
        check("t3_err",   32'(entry_error),    32'h1);
        check("t3_ready", 32'(password_ready), 32'h0);
        idle(1);
        check("t3_err_off", 32'(entry_error), 32'h0);
        check("t3_pw",      32'(entered_password), 32'h4D2);
        idle(2);

        // 4: CHANGE armed submission of 99
        press(K_CHANGE);
        check("t4_armed_idle", 32'(change_mode), 32'h1);
        press(4'd9);
        press(4'd9);
        check("t4_armed_entry", 32'(change_mode), 32'h1);
        press(K_ENTER);
        check("t4_ready",  32'(password_ready),   32'h1);
        check("t4_change", 32'(change_mode),      32'h1);
        check("t4_pw",     32'(entered_password), 32'd99);
        idle(1);
        check("t4_change_off", 32'(change_mode),    32'h0);
        check("t4_ready_off",  32'(password_ready), 32'h0);
        idle(2);

        // 5: timeout after 16 idle cycles
        press(4'd7);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            check($sformatf("t5_no_err_%0d", i), 32'(entry_error), 32'h0);
        end
        @(negedge clk);
        check("t5_err",    32'(entry_error),  32'h1);
        check("t5_active", 32'(entry_active), 32'h0);
        check("t5_count",  32'(digit_count),  32'd0);
        idle(1);
        check("t5_err_off", 32'(entry_error), 32'h0);
        press(K_ENTER);
        check("t5_enter_ready", 32'(password_ready), 32'h0);
        check("t5_enter_err",   32'(entry_error),    32'h0);
        idle(2);

        // 6: reset mid-entry
        press(4'd5);
        press(4'd6);
        press(4'd7);
        check("t6_count3", 32'(digit_count), 32'd3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_pw",     32'(entered_password), 32'h0);
        check("t6_ready",  32'(password_ready),   32'h0);
        check("t6_change", 32'(change_mode),      32'h0);
        check("t6_active", 32'(entry_active),     32'h0);
        check("t6_count",  32'(digit_count),      32'h0);
        check("t6_err",    32'(entry_error),      32'h0);
        press(K_ENTER);
        check("t6_enter_ready", 32'(password_ready), 32'h0);
        check("t6_enter_err",   32'(entry_error),    32'h0);
        idle(1);
        check("t6_enter_ready2", 32'(password_ready), 32'h0);
        check("t6_enter_err2",   32'(entry_error),    32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
